// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types, op encodings and helpers for the load/store memory controller.
package lsu_mem_ctrl_pkg;

  localparam int unsigned RAM_ADDR_W = 32;
  localparam int unsigned RAM_DATA_W = 32;
  localparam int unsigned OP_W       = 4;
  localparam int unsigned SIZE_W     = 3;

  // {is_store, funct3}
  localparam logic [OP_W-1:0] LSU_LB  = 4'b0000;
  localparam logic [OP_W-1:0] LSU_LH  = 4'b0001;
  localparam logic [OP_W-1:0] LSU_LW  = 4'b0010;
  localparam logic [OP_W-1:0] LSU_LBU = 4'b0100;
  localparam logic [OP_W-1:0] LSU_LHU = 4'b0101;
  localparam logic [OP_W-1:0] LSU_SB  = 4'b1000;
  localparam logic [OP_W-1:0] LSU_SH  = 4'b1001;
  localparam logic [OP_W-1:0] LSU_SW  = 4'b1010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_ACC0 = 2'd1,
    LSU_ACC1 = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } lsu_req_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU,
      LSU_SB, LSU_SH, LSU_SW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [SIZE_W-1:0] op_size(input logic [1:0] size_code);
    case (size_code)
      2'b00:   return SIZE_W'(1);
      2'b01:   return SIZE_W'(2);
      default: return SIZE_W'(4);
    endcase
  endfunction

  // Sign/zero extension of the assembled load bytes by funct3.
  function automatic logic [RAM_DATA_W-1:0] load_extend(input logic [2:0]            funct3,
                                                        input logic [RAM_DATA_W-1:0] b);
    case (funct3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b001:  return {{16{b[15]}}, b[15:0]};
      3'b100:  return {24'h0, b[7:0]};
      3'b101:  return {16'h0, b[15:0]};
      default: return b;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Lane mapping for one aligned word of a (possibly split) access: lane mask,
// merged store word and load bytes placed at their position within the access.
module lsu_mem_ctrl_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [1:0]            offset,
  input  logic [SIZE_W-1:0]     size,
  input  logic                  word_idx,
  input  logic [RAM_DATA_W-1:0] store_data,
  input  logic [RAM_DATA_W-1:0] ram_word,
  output logic [3:0]            lane_mask,
  output logic [RAM_DATA_W-1:0] merged,
  output logic [RAM_DATA_W-1:0] load_bytes
);

  logic [3:0] pos;
  logic       hit;

  // pos is the byte's index within the access; the second word starts at 4-offset.
  always_comb begin
    lane_mask  = '0;
    merged     = ram_word;
    load_bytes = '0;
    pos        = '0;
    hit        = 1'b0;
    for (int lane = 0; lane < 4; lane++) begin
      if (word_idx) begin
        pos = 4'd4 - {2'b00, offset} + 4'(lane);
        hit = (offset != 2'b00) && (pos < {1'b0, size});
      end else begin
        pos = 4'(lane) - {2'b00, offset};
        hit = (4'(lane) >= {2'b00, offset}) && (pos < {1'b0, size});
      end
      if (hit) begin
        lane_mask[lane]              = 1'b1;
        merged[8*lane +: 8]          = store_data[8*pos[1:0] +: 8];
        load_bytes[8*pos[1:0] +: 8]  = ram_word[8*lane +: 8];
      end
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store initiator: B/H/W accesses to a word RAM with RMW sub-word
// stores and misaligned accesses split across two aligned words.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
(
  input  logic                  i_Clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [OP_W-1:0]       i_req_op,
  input  logic [RAM_ADDR_W-1:0] i_req_addr,
  input  logic [RAM_DATA_W-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  output logic [RAM_DATA_W-1:0] o_resp_rdata,
  output logic                  o_resp_err,
  output logic [RAM_ADDR_W-1:0] o_r_addr,
  input  logic [RAM_DATA_W-1:0] i_r_data,
  output logic                  o_we,
  output logic [RAM_ADDR_W-1:0] o_w_addr,
  output logic [RAM_DATA_W-1:0] o_w_data
);

  lsu_state_e            state_q, state_d;
  lsu_req_t              req_q;
  logic [RAM_DATA_W-1:0] acc_q;

  logic                  is_store_c;
  logic [SIZE_W-1:0]     size_c;
  logic                  crosses_c;
  logic [RAM_ADDR_W-1:0] word_base_c;
  logic                  in_acc_c;
  logic [3:0]            lane_mask_c;
  logic [RAM_DATA_W-1:0] merged_c;
  logic [RAM_DATA_W-1:0] load_bytes_c;
  logic [RAM_DATA_W-1:0] assembled_c;

  assign is_store_c  = req_q.op[3];
  assign size_c      = op_size(req_q.op[1:0]);
  assign crosses_c   = ({2'b00, req_q.addr[1:0]} + {1'b0, size_c}) > 4'd4;
  assign word_base_c = {req_q.addr[RAM_ADDR_W-1:2], 2'b00};
  assign in_acc_c    = (state_q == LSU_ACC0) || (state_q == LSU_ACC1);

  lsu_mem_ctrl_align u_align (
    .offset     (req_q.addr[1:0]),
    .size       (size_c),
    .word_idx   (state_q == LSU_ACC1),
    .store_data (req_q.wdata),
    .ram_word   (i_r_data),
    .lane_mask  (lane_mask_c),
    .merged     (merged_c),
    .load_bytes (load_bytes_c)
  );

  // First-word bytes are held in acc_q while the second word is read.
  assign assembled_c = ((state_q == LSU_ACC1) ? acc_q : '0) | load_bytes_c;

  always_ff @(posedge i_Clk) begin
    if (i_reset) state_q <= LSU_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_r_addr    = '0;
    o_we        = 1'b0;
    o_w_data    = '0;
    case (state_q)
      LSU_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_d = op_legal(i_req_op) ? LSU_ACC0 : LSU_DONE;
      end
      LSU_ACC0: begin
        o_r_addr = word_base_c;
        o_we     = is_store_c && (|lane_mask_c) && !i_reset;
        o_w_data = merged_c;
        state_d  = crosses_c ? LSU_ACC1 : LSU_DONE;
      end
      LSU_ACC1: begin
        o_r_addr = word_base_c + RAM_ADDR_W'(4);
        o_we     = is_store_c && (|lane_mask_c) && !i_reset;
        o_w_data = merged_c;
        state_d  = LSU_DONE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
    o_w_addr = o_r_addr;
  end

  // Request latch, load accumulator and registered response.
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      req_q        <= '0;
      acc_q        <= '0;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= '0;
      o_resp_err   <= 1'b0;
    end else begin
      if ((state_q == LSU_IDLE) && i_req_valid) begin
        req_q <= '{op: i_req_op, addr: i_req_addr, wdata: i_req_wdata};
      end
      if (in_acc_c) acc_q <= assembled_c;
      o_resp_valid <= (state_d == LSU_DONE);
      o_resp_err   <= (state_q == LSU_IDLE) && (state_d == LSU_DONE);
      o_resp_rdata <= ((state_d == LSU_DONE) && in_acc_c && !is_store_c)
                      ? load_extend(req_q.op[2:0], assembled_c) : '0;
    end
  end

endmodule
